piece_scheduler: RTL and testbench
==================================

PIECE_SCHEDULER -- requirements
Module: piece_scheduler

Interface
REQ-001 Parameter QUEUE_DEPTH, default 4, SHALL set the piece-queue depth (head plus QUEUE_DEPTH-1 preview entries); the only supported value is 4.
REQ-002 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 rand_id  input  3  SHALL be the raw shape code from the randomiser, sampled every cycle; valid codes are 0-6, and 7 SHALL be tolerated.
REQ-005 enable  input  1  SHALL permit queue refill when high; when low, no push occurs.
REQ-006 flush  input  1  SHALL request a synchronous clear of queue and bag.
REQ-007 req  input  1  SHALL request consumption of the head piece.
REQ-008 piece_id  output  3  SHALL present the head piece shape code.
REQ-009 piece_valid  output  1  SHALL indicate that piece_id holds a queued piece.
REQ-010 next1_id, next2_id, next3_id  output  3 each  SHALL present queue entries 1-3 (preview), 0 when the entry is empty.
REQ-011 count  output  3  SHALL report the number of queued entries, 0-4.

Function
REQ-012 The block SHALL hold a queue of up to 4 shape codes and a 7-bit bag mask, where bit k set means code k has been issued in the current bag.
REQ-013 Candidate selection SHALL map rand_id 7 to 0, giving base c; if mask[c]=0 the candidate is c, else the first of c+1..c+6 (mod 7) with mask bit clear.
REQ-014 A push SHALL occur on a cycle when enable=1, flush=0, and (count<4 or a pop occurs that cycle); it appends the candidate at the tail and sets its mask bit.
REQ-015 When a push would make the mask 7'b1111111, the mask SHALL instead become 0 on that edge (new bag); the pushed code SHALL still be queued.
REQ-016 A pop SHALL occur when req=1, piece_valid=1 and flush=0; entries shift toward the head by one on that edge.
REQ-017 Simultaneous pop and push SHALL leave count unchanged, with the new entry at the tail; this SHALL be legal at count=4.
REQ-018 req with piece_valid=0 SHALL be ignored, with no state change.
REQ-019 flush=1 SHALL, on the next edge, set count=0 and mask=0 and zero all outputs, and SHALL override req and push that cycle.
REQ-020 State SHALL be derived from count: EMPTY (0), FILL (1-3) and FULL (4).
  - Transitions: EMPTY->FILL on push.
  - FILL->FULL on push without pop.
  - FULL->FILL on pop without push.
  - FILL->EMPTY on pop without push at count=1.
  - Any state->EMPTY on flush.
REQ-021 piece_valid SHALL equal (count!=0) as a registered value; piece_id and next*_id SHALL be registered queue contents.
REQ-022 Latency: the first push SHALL occur at the first rising edge after reset release with enable=1; piece_valid=1 from that edge; the queue SHALL be full 4 edges after release.
REQ-023 Output piece_id SHALL never equal 7.
REQ-024 Within any bag of 7 consecutive pushes following reset, flush or mask clear, each code 0-6 SHALL appear exactly once.

Reset
REQ-025 Asserting reset (low) SHALL immediately force count=0, mask=0, piece_valid=0, and piece_id and next1-3_id to 0, regardless of clock.
REQ-026 Reset asserted mid-operation SHALL discard queue and bag contents; after release, behaviour SHALL match REQ-022.
REQ-027 Inputs SHALL have no effect while reset is low.

Verification
REQ-028 rand_id held at 3, enable=1, req=0 after reset release -> queue 3,4,5,6 after 4 edges, count=4, piece_valid=1, no further pushes.
REQ-029 rand_id=3, enable=1, req=1 continuously -> push sequence 3,4,5,6,0,1,2,3,4 with mask cleared after the 7th push; no code repeats within a bag.
REQ-030 rand_id held at 7 -> first pushes 0,1,2,3; piece_id never 7.
REQ-031 Full queue with req=1 and enable=1 for one cycle -> count stays 4, head advances, new tail = candidate.
REQ-032 flush=1 together with req=1 at count=4 -> next edge count=0, piece_valid=0, all ids 0; refill resumes the following cycle with a fresh bag.
REQ-033 reset pulsed low mid-fill (count=2), asynchronous to clock -> outputs zero immediately; after release, refill per REQ-028; req while empty is ignored.

Source files
------------

// File: rtl/piece_scheduler.sv
// ---------------------------------------------------------------------------
// piece_scheduler
//   Bag-randomised piece queue. Holds up to QUEUE_DEPTH shape codes (head plus
//   preview entries) and a 7-bit bag mask of codes already issued in the
//   current bag. Each refill takes the raw randomiser code (7 is folded to 0).
//   If that code is already in the bag, the next unused code (mod 7) is taken
//   instead, so every bag of 7 pushes contains each code 0-6 exactly once.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   rand_id[2:0] raw shape code from the randomiser, sampled every cycle
//   enable       permits refill pushes
//   flush        synchronous clear of queue and bag (overrides req/push)
//   req          consume the head piece
//   piece_id     head shape code (registered)
//   piece_valid  head holds a queued piece (registered, count != 0)
//   next1..3_id  preview entries 1-3, 0 when empty
//   count        number of queued entries, 0-4
// ---------------------------------------------------------------------------
module piece_scheduler #(
   parameter int QUEUE_DEPTH = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] rand_id,
   input  logic       enable,
   input  logic       flush,
   input  logic       req,
   output logic [2:0] piece_id,
   output logic       piece_valid,
   output logic [2:0] next1_id,
   output logic [2:0] next2_id,
   output logic [2:0] next3_id,
   output logic [2:0] count
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FILL  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t     state;
   logic [2:0] queue_q [QUEUE_DEPTH];
   logic [6:0] mask;

   logic       pop;
   logic       push;
   logic [2:0] cand;
   logic [2:0] tail;
   logic [2:0] count_nxt;
   logic [6:0] mask_set;
   logic [6:0] mask_nxt;
   logic [2:0] queue_nxt [QUEUE_DEPTH];

   // Fold code 7 onto 0, then walk forward (mod 7) to the first code not yet
   // issued in this bag. The mask is never all ones, so a free code exists.
   function automatic logic [2:0] pick_candidate(input logic [2:0] raw,
                                                 input logic [6:0] m);
      int base;
      int idx;
      logic found;
      logic [2:0] res;
      base  = (raw == 3'd7) ? 0 : int'(raw);
      found = 1'b0;
      res   = 3'(base);
      for (int off = 0; off < 7; off++) begin
         idx = base + off;
         if (idx >= 7) idx = idx - 7;
         if (!found && !m[idx]) begin
            res   = 3'(idx);
            found = 1'b1;
         end
      end
      return res;
   endfunction

   always_comb begin
      pop       = req && piece_valid && !flush;
      // A pop frees a slot on the same edge, so a full queue may still accept.
      push      = enable && !flush && ((state != ST_FULL) || pop);
      cand      = pick_candidate(rand_id, mask);
      tail      = count - {2'b00, pop};
      count_nxt = count + {2'b00, push} - {2'b00, pop};
      mask_set  = mask | (7'b000_0001 << cand);
      // Completing a bag starts a fresh one instead of saturating the mask.
      mask_nxt  = (mask_set == 7'h7f) ? 7'h00 : mask_set;

      // Shift toward the head on pop; vacated tail slots are zero-filled so
      // preview outputs read 0 for empty entries.
      for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
         queue_nxt[i] = pop ? queue_q[i+1] : queue_q[i];
      end
      queue_nxt[QUEUE_DEPTH-1] = pop ? 3'd0 : queue_q[QUEUE_DEPTH-1];

      for (int i = 0; i < QUEUE_DEPTH; i++) begin
         if (push && (tail == 3'(i))) queue_nxt[i] = cand;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= ST_EMPTY;
         count       <= 3'd0;
         mask        <= 7'h00;
         piece_valid <= 1'b0;
         for (int i = 0; i < QUEUE_DEPTH; i++) queue_q[i] <= 3'd0;
      end else if (flush) begin
         state       <= ST_EMPTY;
         count       <= 3'd0;
         mask        <= 7'h00;
         piece_valid <= 1'b0;
         for (int i = 0; i < QUEUE_DEPTH; i++) queue_q[i] <= 3'd0;
      end else begin
         count       <= count_nxt;
         piece_valid <= (count_nxt != 3'd0);
         if (push) mask <= mask_nxt;
         for (int i = 0; i < QUEUE_DEPTH; i++) queue_q[i] <= queue_nxt[i];
         if (count_nxt == 3'd0)
            state <= ST_EMPTY;
         else if (count_nxt == 3'(QUEUE_DEPTH))
            state <= ST_FULL;
         else
            state <= ST_FILL;
      end
   end

   assign piece_id = queue_q[0];
   assign next1_id = queue_q[1];
   assign next2_id = queue_q[2];
   assign next3_id = queue_q[3];

endmodule

// File: tb/tb_piece_scheduler.sv
// ---------------------------------------------------------------------------
// tb_piece_scheduler
//   Scoreboard bench for piece_scheduler: a reference model predicts the
//   outputs after each edge, the prediction is queued when the stimulus is
//   driven and popped/compared once the DUT has updated.
// ---------------------------------------------------------------------------
module tb_piece_scheduler;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] rand_id = 3'd0;
   logic       enable = 1'b0;
   logic       flush = 1'b0;
   logic       req = 1'b0;
   logic [2:0] piece_id;
   logic       piece_valid;
   logic [2:0] next1_id;
   logic [2:0] next2_id;
   logic [2:0] next3_id;
   logic [2:0] count;

   piece_scheduler #(.QUEUE_DEPTH(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .rand_id     (rand_id),
      .enable      (enable),
      .flush       (flush),
      .req         (req),
      .piece_id    (piece_id),
      .piece_valid (piece_valid),
      .next1_id    (next1_id),
      .next2_id    (next2_id),
      .next3_id    (next3_id),
      .count       (count)
   );

   always #5 clock = ~clock;

   typedef struct {
      int pid;
      int pv;
      int n1;
      int n2;
      int n3;
      int cnt;
   } exp_t;

   exp_t exp_q[$];
   int   mq[$];
   bit [6:0] mmask;
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int model_cand(int raw);
      int base;
      base = (raw == 7) ? 0 : raw;
      for (int k = 0; k < 7; k++) begin
         if (!mmask[(base + k) % 7]) return (base + k) % 7;
      end
      return base;
   endfunction

   task automatic model_step(int r, bit en, bit fl, bit rq);
      bit pop_m;
      bit push_m;
      int c;
      if (fl) begin
         mq.delete();
         mmask = '0;
         return;
      end
      pop_m  = rq && (mq.size() > 0);
      push_m = en && ((mq.size() < 4) || pop_m);
      c      = model_cand(r);
      if (pop_m) void'(mq.pop_front());
      if (push_m) begin
         mq.push_back(c);
         mmask[c] = 1'b1;
         if (mmask == 7'h7f) mmask = '0;
      end
   endtask

   function automatic int qent(int i);
      return (i < mq.size()) ? mq[i] : 0;
   endfunction

   // One clock: predict from the inputs now driven, then compare after the edge.
   task automatic cycle();
      exp_t e;
      if (!reset) begin
         mq.delete();
         mmask = '0;
      end else begin
         model_step(int'(rand_id), enable, flush, req);
      end
      e.pid = qent(0);
      e.pv  = (mq.size() != 0) ? 1 : 0;
      e.n1  = qent(1);
      e.n2  = qent(2);
      e.n3  = qent(3);
      e.cnt = mq.size();
      exp_q.push_back(e);
      @(posedge clock);
      #1;
      e = exp_q.pop_front();
      check_val("sb_piece_id", 32'(piece_id), 32'(e.pid));
      check_val("sb_piece_valid", 32'(piece_valid), 32'(e.pv));
      check_val("sb_next1", 32'(next1_id), 32'(e.n1));
      check_val("sb_next2", 32'(next2_id), 32'(e.n2));
      check_val("sb_next3", 32'(next3_id), 32'(e.n3));
      check_val("sb_count", 32'(count), 32'(e.cnt));
      check_val("pid_not7", 32'(piece_id == 3'd7), 32'd0);
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, "_count"}, 32'(count), 32'd0);
      check_val({tag, "_valid"}, 32'(piece_valid), 32'd0);
      check_val({tag, "_ids"}, 32'({piece_id, next1_id, next2_id, next3_id}), 32'd0);
   endtask

   task automatic check_queue(input string tag, input int a, input int b,
                              input int c, input int d, input int cnt);
      check_val({tag, "_head"}, 32'(piece_id), 32'(a));
      check_val({tag, "_n1"}, 32'(next1_id), 32'(b));
      check_val({tag, "_n2"}, 32'(next2_id), 32'(c));
      check_val({tag, "_n3"}, 32'(next3_id), 32'(d));
      check_val({tag, "_count"}, 32'(count), 32'(cnt));
   endtask

   initial begin
      int seq29[9];
      int seq30[4];
      seq29 = '{3, 4, 5, 6, 0, 1, 2, 3, 4};
      seq30 = '{0, 1, 2, 3};

      // Reset held from time zero
      #23;
      check_zero("reset_state");

      // Fill with rand_id=3, no requests
      reset   = 1'b1;
      rand_id = 3'd3;
      enable  = 1'b1;
      cycle();
      check_val("first_push_valid", 32'(piece_valid), 32'd1);
      check_val("first_push_id", 32'(piece_id), 32'd3);
      repeat (3) cycle();
      check_queue("fill4", 3, 4, 5, 6, 4);
      repeat (2) cycle();
      check_queue("full_hold", 3, 4, 5, 6, 4);

      // Pop and push together at full: bag holds 3..6, so candidate wraps to 0
      req = 1'b1;
      cycle();
      req = 1'b0;
      check_queue("popush_full", 4, 5, 6, 0, 4);

      // Flush with req at full
      flush = 1'b1;
      req   = 1'b1;
      cycle();
      check_zero("flush");
      flush = 1'b0;
      req   = 1'b0;
      cycle();
      check_queue("refill_fresh_bag", 3, 0, 0, 0, 1);

      // Continuous requests: push sequence across a bag boundary
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      req   = 1'b1;
      for (int i = 0; i < 9; i++) begin
         cycle();
         check_val($sformatf("bag_seq%0d", i), 32'(piece_id), 32'(seq29[i]));
      end
      req = 1'b0;

      // rand_id stuck at 7
      flush = 1'b1;
      cycle();
      flush   = 1'b0;
      rand_id = 3'd7;
      for (int i = 0; i < 4; i++) begin
         cycle();
         check_val($sformatf("rand7_tail%0d", i), 32'(count), 32'(i + 1));
      end
      check_queue("rand7_queue", seq30[0], seq30[1], seq30[2], seq30[3], 4);

      // Random traffic checked by the scoreboard
      for (int i = 0; i < 400; i++) begin
         rand_id = 3'($urandom_range(0, 7));
         enable  = ($urandom_range(0, 3) != 0);
         req     = ($urandom_range(0, 1) != 0);
         flush   = ($urandom_range(0, 19) == 0);
         cycle();
      end

      // Asynchronous reset mid-fill at count=2
      flush   = 1'b1;
      req     = 1'b0;
      enable  = 1'b1;
      rand_id = 3'd5;
      cycle();
      flush = 1'b0;
      repeat (2) cycle();
      check_val("midfill_count", 32'(count), 32'd2);
      #2;
      reset = 1'b0;
      #1;
      check_zero("async_reset");
      for (int i = 0; i < 3; i++) begin
         rand_id = 3'($urandom_range(0, 7));
         req     = 1'b1;
         flush   = 1'b0;
         enable  = 1'b1;
         cycle();
      end
      check_zero("reset_held");
      reset  = 1'b1;
      enable = 1'b0;
      req    = 1'b1;
      cycle();
      check_zero("req_empty");
      req     = 1'b0;
      enable  = 1'b1;
      rand_id = 3'd3;
      repeat (4) cycle();
      check_queue("refill_after_reset", 3, 4, 5, 6, 4);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
